// File: rtl/colocar_barcos_param.sv
// Ship placement engine for a parameterised N x N board.
// Ships of length num_barcos down to 1 are placed one at a time. Each request is
// bounds-checked, then validated one cell per cycle, and written only if every
// target cell is empty.
module colocar_barcos_param #(
  parameter int unsigned N       = 5,
  parameter int unsigned MAX_LEN = 5,
  parameter int unsigned CELL_W  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              habilitar,
  input  logic [$clog2(MAX_LEN+1)-1:0]      num_barcos,
  input  logic                              colocar,
  input  logic                              vertical,
  input  logic [$clog2(N)-1:0]              fila,
  input  logic [$clog2(N)-1:0]              columna,
  input  logic [N*N*CELL_W-1:0]             matriz_in,
  output logic [N*N*CELL_W-1:0]             matriz_out,
  output logic [$clog2(MAX_LEN+1)-1:0]      barco_actual,
  output logic                              ocupado,
  output logic                              aceptado,
  output logic                              rechazo,
  output logic                              barcos_colocados
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned BW = N * N * CELL_W;
  localparam int unsigned IW = $clog2(BW);

  typedef enum logic [2:0] {
    IDLE, CARGA, ESPERA, VALIDAR, ESCRIBIR, LISTO
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   board_q;
  logic [LW-1:0]   barco_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   k_q;
  logic [CW-1:0]   fila_q;
  logic [CW-1:0]   col_q;
  logic            vert_q;
  logic            ocupado_q;
  logic            aceptado_q;
  logic            rechazo_q;
  logic            listo_q;

  logic [LW-1:0]     load_len;
  logic              place_ok;
  logic [CELL_W-1:0] cell_val;

  // Bit offset of ship cell k, stepping back from the anchor along the axis.
  function automatic logic [IW-1:0] cell_base(input logic [CW-1:0] f,
                                               input logic [CW-1:0] c,
                                               input logic          v,
                                               input int unsigned   k);
    int unsigned r;
    int unsigned cc;
    r  = v ? 32'(f) - k : 32'(f);
    cc = v ? 32'(c) : 32'(c) - k;
    return IW'((r * N + cc) * CELL_W);
  endfunction

  // Clamped ship count, bounds check for a new request, and the cell under test.
  always_comb begin
    load_len = (num_barcos > LW'(MAX_LEN)) ? LW'(MAX_LEN) : num_barcos;
    place_ok = (32'(fila) < N) && (32'(columna) < N) &&
               ((32'(vertical ? fila : columna) + 32'd1) >= 32'(barco_q));
    cell_val = board_q[cell_base(fila_q, col_q, vert_q, 32'(k_q)) +: CELL_W];
  end

  // Placement FSM with registered status outputs and working board.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      board_q    <= '0;
      barco_q    <= '0;
      len_q      <= '0;
      k_q        <= '0;
      fila_q     <= '0;
      col_q      <= '0;
      vert_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      aceptado_q <= 1'b0;
      rechazo_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      aceptado_q <= 1'b0;
      rechazo_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (habilitar) begin
            state_q   <= CARGA;
            ocupado_q <= 1'b1;
          end
        end
        CARGA: begin
          board_q   <= matriz_in;
          barco_q   <= load_len;
          ocupado_q <= 1'b0;
          if (load_len == '0) begin
            state_q <= LISTO;
            listo_q <= 1'b1;
          end else begin
            state_q <= ESPERA;
          end
        end
        ESPERA: begin
          if (!habilitar) begin
            state_q <= IDLE;
          end else if (colocar) begin
            fila_q <= fila;
            col_q  <= columna;
            vert_q <= vertical;
            len_q  <= barco_q;
            k_q    <= '0;
            if (place_ok) begin
              state_q   <= VALIDAR;
              ocupado_q <= 1'b1;
            end else begin
              rechazo_q <= 1'b1;
            end
          end
        end
        VALIDAR: begin
          if (cell_val != '0) begin
            state_q   <= ESPERA;
            ocupado_q <= 1'b0;
            rechazo_q <= 1'b1;
          end else if (k_q == LW'(len_q - LW'(1))) begin
            // Board is written on entry so it is visible alongside aceptado in ESCRIBIR.
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
              if (k < 32'(len_q)) begin
                board_q[cell_base(fila_q, col_q, vert_q, k) +: CELL_W] <= CELL_W'(len_q);
              end
            end
            aceptado_q <= 1'b1;
            barco_q    <= LW'(barco_q - LW'(1));
            state_q    <= ESCRIBIR;
          end else begin
            k_q <= LW'(k_q + LW'(1));
          end
        end
        ESCRIBIR: begin
          ocupado_q <= 1'b0;
          if (barco_q == '0) begin
            state_q <= LISTO;
            listo_q <= 1'b1;
          end else begin
            state_q <= ESPERA;
          end
        end
        LISTO: begin
          if (!habilitar) begin
            state_q <= IDLE;
            listo_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ocupado_q <= 1'b0;
          listo_q   <= 1'b0;
        end
      endcase
    end
  end

  assign matriz_out       = board_q;
  assign barco_actual     = barco_q;
  assign ocupado          = ocupado_q;
  assign aceptado         = aceptado_q;
  assign rechazo          = rechazo_q;
  assign barcos_colocados = listo_q;

endmodule

// File: tb/tb_colocar_barcos_param.sv
// Bench for colocar_barcos_param: request table with a result scoreboard,
// plus hand sequences for loading, LISTO, clamping and asynchronous reset.
module tb_colocar_barcos_param;

  localparam int N      = 5;
  localparam int MAXL   = 5;
  localparam int CELL_W = 3;
  localparam int LW     = 3;
  localparam int CW     = 3;
  localparam int BW     = N * N * CELL_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          habilitar;
  logic [LW-1:0] num_barcos;
  logic          colocar;
  logic          vertical;
  logic [CW-1:0] fila;
  logic [CW-1:0] columna;
  logic [BW-1:0] matriz_in;
  logic [BW-1:0] matriz_out;
  logic [LW-1:0] barco_actual;
  logic          ocupado;
  logic          aceptado;
  logic          rechazo;
  logic          barcos_colocados;

  colocar_barcos_param #(.N(N), .MAX_LEN(MAXL), .CELL_W(CELL_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .habilitar        (habilitar),
    .num_barcos       (num_barcos),
    .colocar          (colocar),
    .vertical         (vertical),
    .fila             (fila),
    .columna          (columna),
    .matriz_in        (matriz_in),
    .matriz_out       (matriz_out),
    .barco_actual     (barco_actual),
    .ocupado          (ocupado),
    .aceptado         (aceptado),
    .rechazo          (rechazo),
    .barcos_colocados (barcos_colocados)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int c;
    bit v;
    bit acc;
    int lat;
    int barco;
  } req_t;

  typedef struct {
    bit acc;
    int t;
    int lat;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            cur_len;
  logic [BW-1:0] model;
  logic [BW-1:0] init2;
  req_t          tab[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int f, input int c,
                                        input bit v, input int len);
    for (int k = 0; k < len; k++) begin
      int r;
      int cc;
      r  = v ? f - k : f;
      cc = v ? c : c - k;
      b[(r * N + cc) * CELL_W +: CELL_W] = CELL_W'(len);
    end
    return b;
  endfunction

  // Scoreboard: every result pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (aceptado || rechazo) begin
      chk("exclusive_pulse", {aceptado, rechazo}, 2'(aceptado ? 2'b10 : 2'b01));
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {aceptado, rechazo}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_kind", aceptado, e.acc);
        chk("result_latency", cyc - e.t + 1, e.lat);
      end
    end
  end

  task automatic check_idle(input string nm);
    chk({nm, "_board"}, matriz_out, '0);
    chk({nm, "_barco"}, barco_actual, '0);
    chk({nm, "_flags"}, {ocupado, aceptado, rechazo, barcos_colocados}, 4'b0000);
  endtask

  task automatic start(input logic [LW-1:0] nb, input logic [BW-1:0] init, input int exp_barco);
    @(negedge clk);
    num_barcos = nb;
    matriz_in  = init;
    habilitar  = 1'b1;
    @(negedge clk); #1;
    chk("carga_ocupado", ocupado, 1'b1);
    @(negedge clk); #1;
    chk("carga_barco", barco_actual, exp_barco);
    chk("carga_board", matriz_out, init);
    chk("carga_listo", barcos_colocados, exp_barco == 0);
    chk("carga_free", ocupado, 1'b0);
    model   = init;
    cur_len = exp_barco;
  endtask

  task automatic req(input req_t r);
    int len;
    len = cur_len;
    @(negedge clk);
    fila     = CW'(r.f);
    columna  = CW'(r.c);
    vertical = r.v;
    colocar  = 1'b1;
    sb.push_back('{acc: r.acc, t: cyc + 1, lat: r.lat});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) colocar = 1'b0;
      #1;
      if (sb.size() == 0) break;
    end
    chk("response_seen", sb.size(), 0);
    sb.delete();
    if (r.acc) model = put(model, r.f, r.c, r.v, len);
    chk("board_after_req", matriz_out, model);
    chk("barco_after_req", barco_actual, r.barco);
    cur_len = r.barco;
  endtask

  initial begin
    // f, c, v, accepted, latency, barco_actual afterwards
    tab[0] = '{1, 1, 0, 0, 1, 3};  // horizontal runs off the left edge
    tab[1] = '{2, 4, 0, 1, 4, 2};  // cells (2,2..4) = 3
    tab[2] = '{5, 0, 0, 0, 1, 2};  // fila outside board
    tab[3] = '{3, 6, 1, 0, 1, 2};  // columna outside board
    tab[4] = '{2, 3, 1, 0, 2, 2};  // first cell already occupied
    tab[5] = '{0, 4, 1, 0, 1, 2};  // vertical runs off the top edge
    tab[6] = '{4, 2, 1, 1, 3, 1};  // cells (3,2),(4,2) = 2
    tab[7] = '{2, 2, 0, 0, 2, 1};  // length-1 ship on occupied cell
    tab[8] = '{0, 0, 0, 1, 2, 0};  // last ship, corner cell

    reset      = 1'b1;
    habilitar  = 1'b0;
    colocar    = 1'b0;
    vertical   = 1'b0;
    fila       = '0;
    columna    = '0;
    num_barcos = 3'd3;
    matriz_in  = {BW{1'b1}};
    model      = '0;
    cur_len    = 0;
    #12;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("idle_without_enable");

    // Session 1: empty board, ships of length 3, 2, 1.
    start(3'd3, '0, 3);
    foreach (tab[i]) req(tab[i]);
    @(negedge clk); #1;
    chk("listo_flag", barcos_colocados, 1'b1);
    chk("listo_ocupado", ocupado, 1'b0);
    fila = 3'd4; columna = 3'd4; vertical = 1'b0; colocar = 1'b1;
    @(negedge clk);
    colocar = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("listo_ignores_colocar", matriz_out, model);
    chk("listo_still_set", barcos_colocados, 1'b1);
    habilitar = 1'b0;
    @(negedge clk); #1;
    chk("listo_to_idle", barcos_colocados, 1'b0);
    chk("idle_board_held", matriz_out, model);

    // Session 2: preloaded ship at (2,2..4); vertical len 3 conflicts at k=2.
    init2 = put('0, 2, 4, 1'b0, 3);
    start(3'd3, init2, 3);
    req('{4, 3, 1, 0, 4, 3});
    habilitar = 1'b0;
    @(negedge clk); #1;
    chk("espera_to_idle_board", matriz_out, init2);
    chk("espera_to_idle_barco", barco_actual, 3);

    // Session 3: num_barcos above MAX_LEN clamps; then reset in mid-validation.
    start(3'd7, '0, 5);
    req('{4, 4, 1, 1, 6, 4});
    req('{0, 0, 0, 0, 1, 4});
    @(negedge clk);
    fila = 3'd4; columna = 3'd3; vertical = 1'b1; colocar = 1'b1;
    @(negedge clk);
    colocar = 1'b0;
    #1;
    chk("validar_ocupado", ocupado, 1'b1);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    habilitar = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("post_reset");

    // Session 4: zero ships goes straight to LISTO.
    start(3'd0, '0, 0);
    habilitar = 1'b0;
    @(negedge clk); #1;
    chk("zero_session_exit", barcos_colocados, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/colocar_barcos_param.md
COLOCAR_BARCOS_PARAM -- requirements
Module: colocar_barcos_param

Interface
REQ-001 SHALL have parameter N, default 5, meaning board side length (cells per row/column, 2..16).
REQ-002 SHALL have parameter MAX_LEN, default 5, meaning longest ship length (1..N).
REQ-003 SHALL have parameter CELL_W, default 3, meaning bits per cell, with 2^CELL_W > MAX_LEN.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port habilitar  in  1  placement session enable (level).
REQ-007 SHALL have port num_barcos  in  $clog2(MAX_LEN+1)  initial ship length; ships placed are num_barcos down to 1.
REQ-008 SHALL have port colocar  in  1  place request (one-cycle pulse).
REQ-009 SHALL have port vertical  in  1  0 = horizontal, 1 = vertical orientation.
REQ-010 SHALL have ports fila, columna  in  $clog2(N) each  anchor cell coordinates.
REQ-011 SHALL have port matriz_in  in  N*N*CELL_W  initial board; cell (i,j) at bits [(i*N+j)*CELL_W +: CELL_W].
REQ-012 SHALL have port matriz_out  out  N*N*CELL_W  working board, same packing.
REQ-013 SHALL have port barco_actual  out  $clog2(MAX_LEN+1)  length of next ship to place.
REQ-014 SHALL have port ocupado  out  1  high in CARGA, VALIDAR, ESCRIBIR.
REQ-015 SHALL have ports aceptado, rechazo  out  1 each  one-cycle result pulses.
REQ-016 SHALL have port barcos_colocados  out  1  high in LISTO.

Function
REQ-017 SHALL implement FSM states IDLE, CARGA, ESPERA, VALIDAR, ESCRIBIR, LISTO.
REQ-018 IDLE: on habilitar=1 SHALL go to CARGA; matriz_out held.
REQ-019 CARGA (1 cycle): SHALL copy matriz_in to working board, load barco_actual = min(num_barcos, MAX_LEN), go to LISTO if that is 0, else ESPERA.
REQ-020 ESPERA: habilitar=0 SHALL go to IDLE (board held); else colocar=1 SHALL latch fila, columna, vertical, len=barco_actual.
REQ-021 Ship cells SHALL be anchor minus k along the axis (columna-k horizontal, fila-k vertical), k = 0..len-1.
REQ-022 Bounds: if fila>=N, columna>=N, or axis coordinate < len-1, SHALL pulse rechazo next cycle and remain ESPERA.
REQ-023 Otherwise SHALL enter VALIDAR, checking one cell per cycle (k=0..len-1); any nonzero cell SHALL abort: rechazo pulse next cycle, return ESPERA, board unchanged.
REQ-024 All len cells zero: SHALL enter ESCRIBIR (1 cycle), write value len to all len cells, pulse aceptado, decrement barco_actual.
REQ-025 Latency: accepted colocar at edge t SHALL give matriz_out updated and aceptado high in cycle t+len+1; conflict at cell k gives rechazo in cycle t+k+2.
REQ-026 After ESCRIBIR SHALL go to LISTO if barco_actual reaches 0, else ESPERA.
REQ-027 LISTO: barcos_colocados=1; habilitar=0 SHALL go to IDLE; further colocar ignored.
REQ-028 colocar outside ESPERA SHALL be ignored (no queueing); habilitar changes only take effect in IDLE, ESPERA, LISTO.
REQ-029 aceptado and rechazo SHALL never be high simultaneously and each SHALL be high at most one cycle per request.
REQ-030 Length-1 ship SHALL validate in 1 cycle like any other (no unconditional placement).

Reset
REQ-031 On reset=1 SHALL immediately enter IDLE, clear working board (matriz_out all zero), barco_actual=0, ocupado=aceptado=rechazo=barcos_colocados=0, irrespective of clk.
REQ-032 Reset mid-VALIDAR or mid-ESCRIBIR SHALL abort with no partial write visible after reset.
REQ-033 After reset release, first action SHALL require habilitar high in IDLE.

Verification
REQ-034 N=5, empty board, num_barcos=3, colocar (2,4,H) -> cycle t+4 aceptado, cells (2,2..4)=3, barco_actual=2.
REQ-035 Then colocar (4,2,V) len 2 with (3,2) empty -> cells (3,2),(4,2)=2; then len-1 at (0,0) -> barcos_colocados=1.
REQ-036 colocar (1,1,H) with len 3 -> rechazo at t+1, board and barco_actual unchanged.
REQ-037 Overlap: ship at (2,2..4), colocar (4,3,V) len 3 -> conflict k=2 at (2,3), rechazo at t+4, no write.
REQ-038 num_barcos=0 -> LISTO one cycle after CARGA, barcos_colocados=1; reset asserted mid-VALIDAR -> all outputs zero, IDLE.
